// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding, sizes and
// a one-hot helper.
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at ptr, ptr+1, ...
// (mod 4).
module rr_priority_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select lines of a 4:1 data mux, with a bounded
// hold time per owner and back-to-back handover.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             owner_release,  // 'release' is a reserved word
  output logic [N_REQ-1:0] grant,
  output logic             S0,
  output logic             S1,
  output logic             busy,
  output logic             timeout
);

  state_t             state;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   ptr;
  logic [HOLD_W-1:0]  cnt;
  logic               found;
  logic [IDX_W-1:0]   idx;
  logic               hold_done;
  logic               owner_gone;

  rr_priority_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (idx)
  );

  assign hold_done  = (cnt == HOLD_W'(MAX_HOLD - 1));
  assign owner_gone = ~req[sel];
  assign S0         = sel[0];
  assign S1         = sel[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= '0;
      sel     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_OWN;
            grant <= onehot(idx);
            sel   <= idx;
            ptr   <= idx + IDX_W'(1);
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_OWN: begin
          if (owner_release || owner_gone || hold_done) begin
            // Timeout is only reported when the hold limit is the actual cause.
            timeout <= ~owner_release & ~owner_gone & hold_done;
            // ptr already points past the owner, so re-arbitrate immediately.
            if (found) begin
              grant <= onehot(idx);
              sel   <= idx;
              ptr   <= idx + IDX_W'(1);
              cnt   <= '0;
            end else begin
              state <= ST_IDLE;
              grant <= '0;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: per-cycle comparison against a behavioural arbiter model
// plus directed literal checks.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       rel = 1'b0;
  logic [3:0] grant;
  logic       S0, S1, busy, timeout;

  int n_total = 0;
  int n_pass  = 0;

  mux_rr_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .owner_release (rel),
    .grant         (grant),
    .S0            (S0),
    .S1            (S1),
    .busy          (busy),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Behavioural model: owner index (-1 when idle), rotating start point,
  // number of cycles the current owner has held the mux.
  int m_owner = -1;
  int m_start = 0;
  int m_held  = 0;
  int m_sel   = 0;
  bit m_to    = 1'b0;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    bit leave;
    if (rst) begin
      m_owner = -1; m_start = 0; m_held = 0; m_sel = 0; m_to = 1'b0;
    end else begin
      m_to  = 1'b0;
      leave = (m_owner < 0);
      if (m_owner >= 0) begin
        leave = rel || !req[m_owner] || (m_held == MAX_HOLD);
        m_to  = !rel && req[m_owner] && (m_held == MAX_HOLD);
      end
      if (leave) begin
        w = pick(req, m_start);
        if (w >= 0) begin
          m_owner = w; m_sel = w; m_start = (w + 1) % 4; m_held = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model grant", grant, (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
      chk("model sel", {S1, S0}, m_sel[1:0]);
      chk("model busy", busy, m_owner >= 0);
      chk("model timeout", timeout, m_to);
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    rel = 1'b0;
    #2 rst = 1'b1;
    edge1();
    rst = 1'b0;
  endtask

  task automatic lit(input string name, input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic t);
    chk({name, " grant"}, grant, g);
    chk({name, " sel"}, {S1, S0}, s);
    chk({name, " busy"}, busy, b);
    chk({name, " timeout"}, timeout, t);
  endtask

  initial begin
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    seq[4] = 4'b0001;

    repeat (2) edge1();
    rst = 1'b0;
    lit("reset", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Single requester, then release with nobody waiting.
    req = 4'b0100;
    edge1();
    lit("single grant", 4'b0100, 2'b10, 1'b1, 1'b0);
    rel = 1'b1; req = 4'b0000;
    edge1();
    rel = 1'b0;
    lit("release idle", 4'b0000, 2'b10, 1'b0, 1'b0);

    // All requesting, release every second cycle.
    do_reset();
    req = 4'b1111;
    edge1();
    chk("rr step 0", grant, seq[0]);
    for (int i = 1; i < 5; i++) begin
      edge1();
      chk("rr no preempt", grant, seq[i-1]);
      rel = 1'b1;
      edge1();
      rel = 1'b0;
      chk("rr step", grant, seq[i]);
    end

    // Asynchronous reset while a grant is active.
    #2 rst = 1'b1;
    #1 lit("async reset", 4'b0000, 2'b00, 1'b0, 1'b0);
    req = 4'b0000;
    edge1();
    rst = 1'b0;

    // Hold timeout with a sole requester, then release colliding with the limit.
    req = 4'b0010;
    edge1();
    lit("hold grant", 4'b0010, 2'b01, 1'b1, 1'b0);
    repeat (7) edge1();
    chk("pre timeout", timeout, 1'b0);
    edge1();
    lit("timeout", 4'b0010, 2'b01, 1'b1, 1'b1);
    edge1();
    chk("timeout pulse end", timeout, 1'b0);
    repeat (6) edge1();
    rel = 1'b1;
    edge1();
    rel = 1'b0;
    lit("release beats timeout", 4'b0010, 2'b01, 1'b1, 1'b0);
    req = 4'b0000;
    edge1();

    // Owner 0 releases with D3 waiting: handover on the same edge.
    do_reset();
    req = 4'b0001;
    edge1();
    chk("owner0 grant", grant, 4'b0001);
    req = 4'b1001;
    edge1();
    chk("owner0 keeps", grant, 4'b0001);
    rel = 1'b1;
    edge1();
    rel = 1'b0;
    lit("handover", 4'b1000, 2'b11, 1'b1, 1'b0);
    req = 4'b0000;
    edge1();

    // Owner 1 drops its request while D2 waits.
    do_reset();
    req = 4'b0010;
    edge1();
    req = 4'b0110;
    edge1();
    chk("owner1 keeps", grant, 4'b0010);
    req = 4'b0100;
    edge1();
    lit("drop handover", 4'b0100, 2'b10, 1'b1, 1'b0);
    req = 4'b0000;
    repeat (2) edge1();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
